hilo_muldiv_controller: RTL and testbench
=========================================

HILO_MULDIV_CONTROLLER -- requirements
Module: hilo_muldiv_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on posedge clk.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high; clears all state immediately, independent of clk.
REQ-003 SHALL have port op_valid, input, 1 bit: an op is presented this cycle.
REQ-004 SHALL have port op_code, input, 3 bits: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 ignored (no accept, no stall).
REQ-005 SHALL have ports operand_a and operand_b, input, 32 bits each: rs and rt values; a = dividend/multiplicand, b = divisor/multiplier; MTHI/MTLO use a only.
REQ-006 SHALL have port hilo_read_request, input, 1 bit: decode holds an MFHI/MFLO this cycle.
REQ-007 SHALL have port busy, output, 1 bit: an iterative op is in progress.
REQ-008 SHALL have port stall, output, 1 bit: the pipeline must hold; combinational.
REQ-009 SHALL have ports HI_write_enable and LO_write_enable, output, 1 bit each: register-file HI/LO write strobes.
REQ-010 SHALL have ports HI_write_data and LO_write_data, output, 32 bits each: values written to HI/LO.

Function
REQ-011 SHALL implement states IDLE, MUL, DIV and DONE; only IDLE accepts ops.
REQ-012 SHALL accept an op in IDLE when op_valid=1 and op_code is legal (cycle 0); operands are latched into internal registers at that edge.
REQ-013 For MULT/MULTU: SHALL enter MUL, run 32 shift-add iterations on operand magnitudes (cycles 1-32), then enter DONE (cycle 33).
REQ-014 For DIV/DIVU: SHALL enter DIV, run 32 restoring-division iterations on magnitudes (cycles 1-32), then enter DONE (cycle 33).
REQ-015 Signed ops: product sign = sign(a) XOR sign(b); quotient truncates toward zero; remainder takes the sign of the dividend; unsigned ops apply no sign correction.
REQ-016 Result mapping: multiply gives HI = product[63:32] and LO = product[31:0]; divide gives LO = quotient and HI = remainder.
REQ-017 Divide by zero: LO = 0xFFFFFFFF, HI = operand_a; no error flag.
REQ-018 DIV of 0x80000000 by 0xFFFFFFFF: LO = 0x80000000, HI = 0x00000000.
REQ-019 In DONE: HI_write_enable and LO_write_enable SHALL both be 1 for exactly one cycle with the result data, then the block returns to IDLE.
REQ-020 MTHI/MTLO accepted in IDLE: the block SHALL register the strobe, asserting only HI_write_enable (MTHI) or only LO_write_enable (MTLO) for one cycle at cycle 1, with data = operand_a; the FSM stays in IDLE.
REQ-021 busy SHALL be 1 in MUL, DIV and DONE and 0 in IDLE; it is high for exactly cycles 1-33.
REQ-022 stall = busy AND (hilo_read_request OR (op_valid AND legal op_code)); ops presented while busy are not accepted and must be held by the source.
REQ-023 A stalled MFHI/MFLO SHALL be released in the first cycle busy=0, i.e. after the DONE write edge, so it reads the new value.
REQ-024 Back-to-back accepts: an op presented in the first IDLE cycle after DONE SHALL be accepted in that cycle.
REQ-025 An op accepted in IDLE while an MTHI/MTLO strobe from the previous cycle is outputting SHALL be accepted normally; the strobe is not cancelled.
REQ-026 Write enables SHALL be 0 in every cycle not specified above; write data is don't-care when its enable is 0.

Reset
REQ-027 On reset=1, the block SHALL asynchronously enter IDLE with busy=0, both write enables=0, write data=0 and the iteration counter=0.
REQ-028 Reset during MUL, DIV or DONE SHALL abort the op with no HI/LO write, including when reset coincides with a DONE cycle.
REQ-029 After reset deasserts, the first posedge SHALL be able to accept an op.

Verification
REQ-030 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy cycles 1-33; at cycle 33 HI=0xFFFFFFFE, LO=0x00000001, both enables high for one cycle.
REQ-031 MULT a=0xFFFFFFFD (-3), b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-032 DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU a=100, b=0 -> LO=0xFFFFFFFF, HI=100.
REQ-033 With hilo_read_request=1 from cycle 5 during DIVU 100/7 -> stall high cycles 5-33 and low at cycle 34; LO=14 and HI=2 are written at cycle 33.
REQ-034 MTLO a=0x12345678 in IDLE -> LO_write_enable=1 and LO_write_data=0x12345678 at cycle 1 only, HI_write_enable=0; MULT presented at cycle 10 of a busy DIV -> stall=1 and the MULT is not accepted until IDLE.
REQ-035 Reset asserted at cycle 20 of MULT -> busy=0 immediately with no write enables; a new DIVU accepted after release completes normally.

Source files
------------

// File: rtl/hilo_muldiv_controller.sv
// Purpose: iterative MIPS HI/LO multiply/divide unit plus MTHI/MTLO strobes.
// Latency: MUL/DIV accepted at cycle 0, busy cycles 1-33, HI+LO written in cycle 33; MTHI/MTLO write at cycle 1.
// Backpressure: ops are only taken in IDLE; while busy, stall holds any legal op or MFHI/MFLO at the source.
//
// Ports:
//   clk, reset                        - clock, asynchronous active-high reset
//   op_valid, op_code, operand_a/b    - op request (a = rs, b = rt)
//   hilo_read_request                 - decode holds an MFHI/MFLO
//   busy, stall                       - iterative op in flight / pipeline hold (combinational)
//   HI/LO_write_enable, HI/LO_write_data - register-file write port for HI and LO
module hilo_muldiv_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        hilo_read_request,
    output logic        busy,
    output logic        stall,
    output logic        HI_write_enable,
    output logic        LO_write_enable,
    output logic [31:0] HI_write_data,
    output logic [31:0] LO_write_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    state_t      state;
    logic [4:0]  iter_cnt;
    // Shared datapath: acc_hi is product-high / partial remainder,
    // acc_lo is multiplier-shifting-out / quotient-shifting-in,
    // opnd is the multiplicand or divisor magnitude.
    logic [31:0] acc_hi;
    logic [31:0] acc_lo;
    logic [31:0] opnd;
    logic [31:0] raw_a;
    logic        is_signed;
    logic        neg_a;
    logic        neg_b;
    logic        div_by_zero;

    logic        op_legal;
    logic        accept;
    logic        signed_op;
    logic [31:0] mag_a;
    logic [31:0] mag_b;

    logic [32:0] mul_sum;
    logic [31:0] mul_hi_nxt;
    logic [31:0] mul_lo_nxt;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [31:0] div_hi_nxt;
    logic [31:0] div_lo_nxt;

    logic [63:0] prod_raw;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] div_hi_res;
    logic [31:0] div_lo_res;

    assign op_legal = (op_code <= OP_MTLO);
    assign accept   = op_valid && op_legal && (state == S_IDLE);
    assign stall    = busy && (hilo_read_request || (op_valid && op_legal));

    // MULT and DIV are the even codes of the four arithmetic ops.
    assign signed_op = ~op_code[0];
    assign mag_a     = (signed_op && operand_a[31]) ? (32'd0 - operand_a) : operand_a;
    assign mag_b     = (signed_op && operand_b[31]) ? (32'd0 - operand_b) : operand_b;

    // One shift-add multiply step: add multiplicand when the multiplier LSB
    // is set, then shift the 64-bit {hi,lo} pair right by one.
    always_comb begin
        mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : 33'd0);
        mul_hi_nxt = mul_sum[32:1];
        mul_lo_nxt = {mul_sum[0], acc_lo[31:1]};
    end

    // One restoring-division step: bring in the next dividend bit, try the
    // subtraction, keep it only if it did not borrow.
    always_comb begin
        div_shift = {acc_hi, acc_lo[31]};
        div_diff  = div_shift - {1'b0, opnd};
        if (!div_diff[32]) begin
            div_hi_nxt = div_diff[31:0];
        end else begin
            div_hi_nxt = div_shift[31:0];
        end
        div_lo_nxt = {acc_lo[30:0], ~div_diff[32]};
    end

    // Final results are formed from the last iteration's next-state values so
    // the write data can be registered on the edge that enters DONE.
    always_comb begin
        prod_raw = {mul_hi_nxt, mul_lo_nxt};
        prod_fix = (is_signed && (neg_a ^ neg_b)) ? (64'd0 - prod_raw) : prod_raw;

        quo_fix  = (is_signed && (neg_a ^ neg_b)) ? (32'd0 - div_lo_nxt) : div_lo_nxt;
        rem_fix  = (is_signed && neg_a) ? (32'd0 - div_hi_nxt) : div_hi_nxt;

        // Divide by zero reports all-ones quotient and the untouched dividend.
        if (div_by_zero) begin
            div_lo_res = 32'hFFFF_FFFF;
            div_hi_res = raw_a;
        end else begin
            div_lo_res = quo_fix;
            div_hi_res = rem_fix;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_IDLE;
            busy            <= 1'b0;
            iter_cnt        <= 5'd0;
            acc_hi          <= 32'd0;
            acc_lo          <= 32'd0;
            opnd            <= 32'd0;
            raw_a           <= 32'd0;
            is_signed       <= 1'b0;
            neg_a           <= 1'b0;
            neg_b           <= 1'b0;
            div_by_zero     <= 1'b0;
            HI_write_enable <= 1'b0;
            LO_write_enable <= 1'b0;
            HI_write_data   <= 32'd0;
            LO_write_data   <= 32'd0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            HI_write_enable <= 1'b0;
            LO_write_enable <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (op_code)
                            OP_MULT, OP_MULTU: begin
                                state    <= S_MUL;
                                busy     <= 1'b1;
                                iter_cnt <= 5'd0;
                                acc_hi   <= 32'd0;
                                acc_lo   <= mag_b;
                                opnd     <= mag_a;
                            end
                            OP_DIV, OP_DIVU: begin
                                state    <= S_DIV;
                                busy     <= 1'b1;
                                iter_cnt <= 5'd0;
                                acc_hi   <= 32'd0;
                                acc_lo   <= mag_a;
                                opnd     <= mag_b;
                            end
                            OP_MTHI: begin
                                HI_write_enable <= 1'b1;
                                HI_write_data   <= operand_a;
                            end
                            default: begin
                                // OP_MTLO; illegal codes never reach here.
                                LO_write_enable <= 1'b1;
                                LO_write_data   <= operand_a;
                            end
                        endcase
                        is_signed   <= signed_op;
                        neg_a       <= operand_a[31];
                        neg_b       <= operand_b[31];
                        div_by_zero <= (operand_b == 32'd0);
                        raw_a       <= operand_a;
                    end
                end

                S_MUL: begin
                    acc_hi   <= mul_hi_nxt;
                    acc_lo   <= mul_lo_nxt;
                    iter_cnt <= iter_cnt + 5'd1;
                    if (iter_cnt == 5'd31) begin
                        state           <= S_DONE;
                        HI_write_enable <= 1'b1;
                        LO_write_enable <= 1'b1;
                        HI_write_data   <= prod_fix[63:32];
                        LO_write_data   <= prod_fix[31:0];
                    end
                end

                S_DIV: begin
                    acc_hi   <= div_hi_nxt;
                    acc_lo   <= div_lo_nxt;
                    iter_cnt <= iter_cnt + 5'd1;
                    if (iter_cnt == 5'd31) begin
                        state           <= S_DONE;
                        HI_write_enable <= 1'b1;
                        LO_write_enable <= 1'b1;
                        HI_write_data   <= div_hi_res;
                        LO_write_data   <= div_lo_res;
                    end
                end

                S_DONE: begin
                    // busy drops here so a held MFHI/MFLO sees the new HI/LO.
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_controller.sv
// Purpose: directed self-checking bench for hilo_muldiv_controller.
// Latency: cycle n is observed 1 time unit after the n-th edge following acceptance.
// Backpressure: stall is checked directly while ops/reads are held during busy.
module tb_hilo_muldiv_controller;

    logic        clk;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        hilo_read_request;
    logic        busy;
    logic        stall;
    logic        HI_write_enable;
    logic        LO_write_enable;
    logic [31:0] HI_write_data;
    logic [31:0] LO_write_data;

    int total_checks  = 0;
    int passed_checks = 0;

    hilo_muldiv_controller dut (
        .clk               (clk),
        .reset             (reset),
        .op_valid          (op_valid),
        .op_code           (op_code),
        .operand_a         (operand_a),
        .operand_b         (operand_b),
        .hilo_read_request (hilo_read_request),
        .busy              (busy),
        .stall             (stall),
        .HI_write_enable   (HI_write_enable),
        .LO_write_enable   (LO_write_enable),
        .HI_write_data     (HI_write_data),
        .LO_write_data     (LO_write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_checks++;
        assert (obs === exp) passed_checks++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic present(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
        op_valid  = 1'b1;
        op_code   = code;
        operand_a = a;
        operand_b = b;
    endtask

    // Full iterative op from an idle cycle 0 through the first idle cycle 34.
    task automatic run_op(input string tag, input logic [2:0] code, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        present(code, a, b);
        step();                                   // cycle 1
        op_valid = 1'b0;
        check({tag, " busy@1"}, busy, 1);
        repeat (31) step();                       // cycle 32
        check({tag, " we@32"}, {HI_write_enable, LO_write_enable}, 0);
        step();                                   // cycle 33
        check({tag, " busy@33"}, busy, 1);
        check({tag, " we@33"}, {HI_write_enable, LO_write_enable}, 2'b11);
        check({tag, " hi"}, HI_write_data, exp_hi);
        check({tag, " lo"}, LO_write_data, exp_lo);
        step();                                   // cycle 34
        check({tag, " busy@34"}, busy, 0);
        check({tag, " we@34"}, {HI_write_enable, LO_write_enable}, 0);
    endtask

    initial begin
        reset             = 1'b1;
        op_valid          = 1'b0;
        op_code           = 3'b000;
        operand_a         = 32'd0;
        operand_b         = 32'd0;
        hilo_read_request = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst busy", busy, 0);
        check("rst stall", stall, 0);
        check("rst we", {HI_write_enable, LO_write_enable}, 0);
        check("rst hi data", HI_write_data, 0);
        check("rst lo data", LO_write_data, 0);
        reset = 1'b0;

        // Arithmetic vectors, chained back to back (cycle 34 of one is cycle 0 of the next)
        run_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg",  3'b000, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("div_neg",   3'b010, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_dbz",  3'b011, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF);
        run_op("div_dbz",   3'b010, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF);

        // MFHI/MFLO held from cycle 5 of DIVU 100/7
        present(3'b011, 32'd100, 32'd7);
        step();                                   // cycle 1
        op_valid = 1'b0;
        repeat (3) step();                        // cycle 4
        check("rd stall@4", stall, 0);
        step();                                   // cycle 5
        hilo_read_request = 1'b1;
        #1;
        check("rd stall@5", stall, 1);
        repeat (28) step();                       // cycle 33
        check("rd stall@33", stall, 1);
        check("rd we@33", {HI_write_enable, LO_write_enable}, 2'b11);
        check("rd lo", LO_write_data, 14);
        check("rd hi", HI_write_data, 2);
        step();                                   // cycle 34
        check("rd stall@34", stall, 0);
        hilo_read_request = 1'b0;

        // MTLO strobe
        present(3'b101, 32'h1234_5678, 32'hDEAD_BEEF);
        step();                                   // cycle 1
        op_valid = 1'b0;
        check("mtlo we@1", {HI_write_enable, LO_write_enable}, 2'b01);
        check("mtlo data", LO_write_data, 32'h1234_5678);
        check("mtlo busy", busy, 0);
        step();                                   // cycle 2
        check("mtlo we@2", {HI_write_enable, LO_write_enable}, 0);

        // MTHI, then a DIVU accepted while the MTHI strobe is out
        present(3'b100, 32'hCAFE_F00D, 32'd0);
        step();                                   // cycle 1
        check("mthi we@1", {HI_write_enable, LO_write_enable}, 2'b10);
        check("mthi data", HI_write_data, 32'hCAFE_F00D);
        run_op("divu_after_mthi", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14);

        // Illegal op code in IDLE: no accept, no stall
        present(3'b110, 32'd1, 32'd1);
        #1;
        check("ill stall", stall, 0);
        step();
        op_valid = 1'b0;
        check("ill busy", busy, 0);
        check("ill we", {HI_write_enable, LO_write_enable}, 0);

        // DIV overflow case with a MULT held from cycle 10
        present(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        step();                                   // cycle 1
        op_valid = 1'b0;
        repeat (9) step();                        // cycle 10
        present(3'b111, 32'hFFFF_FFFF, 32'h8000_0000);
        #1;
        check("held ill stall", stall, 0);
        op_code = 3'b000;
        #1;
        check("held mult stall", stall, 1);
        repeat (23) step();                       // cycle 33
        check("ovf we", {HI_write_enable, LO_write_enable}, 2'b11);
        check("ovf lo", LO_write_data, 32'h8000_0000);
        check("ovf hi", HI_write_data, 32'h0000_0000);
        check("ovf stall@33", stall, 1);
        step();                                   // cycle 34, MULT accepted here
        check("held busy@34", busy, 0);
        check("held stall@34", stall, 0);
        step();                                   // MULT cycle 1
        op_valid = 1'b0;
        check("held mult busy", busy, 1);
        repeat (32) step();                       // MULT cycle 33
        check("held mult we", {HI_write_enable, LO_write_enable}, 2'b11);
        check("held mult hi", HI_write_data, 32'h0000_0000);
        check("held mult lo", LO_write_data, 32'h8000_0000);
        step();

        // Reset at cycle 20 of a MULT
        present(3'b000, 32'd5, 32'd6);
        step();                                   // cycle 1
        op_valid = 1'b0;
        repeat (19) step();                       // cycle 20
        #2;
        reset = 1'b1;
        #1;
        check("rst20 busy", busy, 0);
        check("rst20 we", {HI_write_enable, LO_write_enable}, 0);
        step();
        check("rst20 held we", {HI_write_enable, LO_write_enable}, 0);
        reset = 1'b0;
        run_op("divu_after_rst", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14);

        // Reset landing in the DONE cycle
        present(3'b011, 32'd100, 32'd7);
        step();                                   // cycle 1
        op_valid = 1'b0;
        repeat (32) step();                       // cycle 33
        check("rstdone we before", {HI_write_enable, LO_write_enable}, 2'b11);
        #2;
        reset = 1'b1;
        #1;
        check("rstdone we", {HI_write_enable, LO_write_enable}, 0);
        check("rstdone busy", busy, 0);
        check("rstdone lo data", LO_write_data, 0);
        step();
        reset = 1'b0;
        step();
        check("rstdone idle busy", busy, 0);
        check("rstdone idle we", {HI_write_enable, LO_write_enable}, 0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
